// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: widths, station tags and requester group indices.
package tomasulo_pkg;

   localparam int unsigned TAG_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 2;

   // Station tags; tag 0 is reserved for "no producer"
   localparam logic [TAG_W-1:0] TAG_NONE = 5'd0;
   localparam logic [TAG_W-1:0] TAG_ADD0 = 5'd1;
   localparam logic [TAG_W-1:0] TAG_ADD1 = 5'd2;
   localparam logic [TAG_W-1:0] TAG_ADD2 = 5'd3;
   localparam logic [TAG_W-1:0] TAG_MUL0 = 5'd4;
   localparam logic [TAG_W-1:0] TAG_MUL1 = 5'd5;
   localparam logic [TAG_W-1:0] TAG_MUL2 = 5'd6;
   localparam logic [TAG_W-1:0] TAG_LOAD0 = 5'd7;
   localparam logic [TAG_W-1:0] TAG_LOAD1 = 5'd8;
   localparam logic [TAG_W-1:0] TAG_LOAD2 = 5'd9;

   // Requester group indices
   localparam logic [IDX_W-1:0] GRP_ADD  = 2'd0;
   localparam logic [IDX_W-1:0] GRP_MUL  = 2'd1;
   localparam logic [IDX_W-1:0] GRP_LOAD = 2'd2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BCAST = 1'b1
   } cdb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick
   import tomasulo_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0]     elig,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     win_oh,
   output logic [IDX_W-1:0] win_idx,
   output logic             any
);

   logic [IDX_W-1:0] cand;

   // Scan N positions starting at ptr; the first eligible one wins
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      any     = 1'b0;
      cand    = '0;
      for (int unsigned off = 0; off < N; off++) begin
         cand = IDX_W'((32'(ptr) + off) % N);
         if (!any && elig[cand]) begin
            any          = 1'b1;
            win_oh[cand] = 1'b1;
            win_idx      = cand;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant of one station group per cycle onto the registered broadcast bus.
module cdb_arbiter #(
   parameter int unsigned N      = 3,
   parameter int unsigned TAG_W  = tomasulo_pkg::TAG_W,
   parameter int unsigned DATA_W = tomasulo_pkg::DATA_W
) (
   input  logic                clk,
   input  logic                nRST,
   input  logic [N-1:0]        Breq,
   input  logic [N*TAG_W-1:0]  BreqLabel,
   input  logic [N*DATA_W-1:0] BreqData,
   input  logic                hold,
   output logic [N-1:0]        BreqAC,
   output logic                BCEN,
   output logic [TAG_W-1:0]    BClabel,
   output logic [DATA_W-1:0]   BCdata,
   output logic [1:0]          grant_idx,
   output logic                zero_tag_err
);
   import tomasulo_pkg::*;

   cdb_state_e state_q, state_d;

   logic [IDX_W-1:0]  rr_ptr, ptr_d;
   logic [N-1:0]      elig, win_oh, ack_d;
   logic [IDX_W-1:0]  win_idx;
   logic [1:0]        gidx_d;
   logic              any, grant, bcen_d, err_d;
   logic [TAG_W-1:0]  win_tag, label_d;
   logic [DATA_W-1:0] win_data, data_d;

   logic [TAG_W-1:0]  lbl_arr [N];
   logic [DATA_W-1:0] dat_arr [N];

   // Unpack the per-group tag/data lanes
   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign lbl_arr[g] = BreqLabel[g*TAG_W +: TAG_W];
      assign dat_arr[g] = BreqData[g*DATA_W +: DATA_W];
   end

   // A group acked this cycle is excluded so it cannot be granted twice in a row
   assign elig = Breq & ~BreqAC;

   rr_pick #(.N(N)) u_pick (
      .elig    (elig),
      .ptr     (rr_ptr),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .any     (any)
   );

   assign grant    = any & ~hold;
   assign win_tag  = lbl_arr[win_idx];
   assign win_data = dat_arr[win_idx];

   // Next state and next register values
   always_comb begin
      state_d = state_q;
      ack_d   = '0;
      bcen_d  = 1'b0;
      label_d = '0;
      data_d  = '0;
      ptr_d   = rr_ptr;
      gidx_d  = grant_idx;
      err_d   = zero_tag_err;

      case (state_q)
         ST_IDLE:  if (grant)  state_d = ST_BCAST;
         ST_BCAST: if (!grant) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (grant) begin
         ack_d  = win_oh;
         gidx_d = 2'(win_idx);
         ptr_d  = IDX_W'((32'(win_idx) + 32'd1) % N);
         if (win_tag != '0) begin
            bcen_d  = (state_d == ST_BCAST);
            label_d = win_tag;
            data_d  = win_data;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // State, pointer and output registers
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q      <= ST_IDLE;
         rr_ptr       <= '0;
         BreqAC       <= '0;
         BCEN         <= 1'b0;
         BClabel      <= '0;
         BCdata       <= '0;
         grant_idx    <= '0;
         zero_tag_err <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr       <= ptr_d;
         BreqAC       <= ack_d;
         BCEN         <= bcen_d;
         BClabel      <= label_d;
         BCdata       <= data_d;
         grant_idx    <= gidx_d;
         zero_tag_err <= err_d;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
   localparam int unsigned N      = 3;
   localparam int unsigned TAG_W  = 5;
   localparam int unsigned DATA_W = 32;

   logic                clk = 1'b0;
   logic                nRST;
   logic [N-1:0]        Breq;
   logic [N*TAG_W-1:0]  BreqLabel;
   logic [N*DATA_W-1:0] BreqData;
   logic                hold;
   logic [N-1:0]        BreqAC;
   logic                BCEN;
   logic [TAG_W-1:0]    BClabel;
   logic [DATA_W-1:0]   BCdata;
   logic [1:0]          grant_idx;
   logic                zero_tag_err;

   int vecs = 0;
   int errs = 0;

   cdb_arbiter #(.N(N), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .nRST         (nRST),
      .Breq         (Breq),
      .BreqLabel    (BreqLabel),
      .BreqData     (BreqData),
      .hold         (hold),
      .BreqAC       (BreqAC),
      .BCEN         (BCEN),
      .BClabel      (BClabel),
      .BCdata       (BCdata),
      .grant_idx    (grant_idx),
      .zero_tag_err (zero_tag_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check the full broadcast bundle
   task automatic chk_bc(input string tag, input logic [2:0] ack, input logic en,
                         input logic [4:0] lbl, input logic [31:0] dat);
      chk({tag, ".ack"},   64'(BreqAC),  64'(ack));
      chk({tag, ".bcen"},  64'(BCEN),    64'(en));
      chk({tag, ".label"}, 64'(BClabel), 64'(lbl));
      chk({tag, ".data"},  64'(BCdata),  64'(dat));
   endtask

   task automatic set_lane(input int g, input logic [4:0] lbl, input logic [31:0] dat);
      BreqLabel[g*TAG_W +: TAG_W]   = lbl;
      BreqData[g*DATA_W +: DATA_W]  = dat;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      #3;
      nRST = 1'b1;
   endtask

   initial begin
      nRST = 1'b0; Breq = '0; BreqLabel = '0; BreqData = '0; hold = 1'b0;
      #12;
      chk_bc("reset", 3'b000, 1'b0, 5'd0, 32'h0);
      chk("reset.gidx", 64'(grant_idx), 64'd0);
      chk("reset.err",  64'(zero_tag_err), 64'd0);
      nRST = 1'b1;
      tick();

      // Single request from group 1
      set_lane(1, 5'd4, 32'h0000_0030); Breq = 3'b010;
      tick();
      chk_bc("single", 3'b010, 1'b1, 5'd4, 32'h30);
      chk("single.gidx", 64'(grant_idx), 64'd1);
      Breq = 3'b000;
      tick();
      chk_bc("single.after", 3'b000, 1'b0, 5'd0, 32'h0);

      // All three at once from a fresh pointer
      do_reset();
      set_lane(0, 5'd1, 32'h100); set_lane(1, 5'd4, 32'h200); set_lane(2, 5'd7, 32'h300);
      Breq = 3'b111;
      tick();
      chk_bc("all.g0", 3'b001, 1'b1, 5'd1, 32'h100);
      Breq[0] = 1'b0;
      tick();
      chk_bc("all.g1", 3'b010, 1'b1, 5'd4, 32'h200);
      chk("all.g1.gidx", 64'(grant_idx), 64'd1);
      Breq[1] = 1'b0;
      tick();
      chk_bc("all.g2", 3'b100, 1'b1, 5'd7, 32'h300);
      chk("all.g2.gidx", 64'(grant_idx), 64'd2);
      Breq[2] = 1'b0;
      tick();
      chk_bc("all.idle", 3'b000, 1'b0, 5'd0, 32'h0);

      // Group 0 re-requests right after its ack while group 2 waits: 0, 2, 0
      set_lane(0, 5'd2, 32'hA0); set_lane(2, 5'd8, 32'hA2);
      Breq = 3'b101;
      tick();
      chk_bc("rereq.0", 3'b001, 1'b1, 5'd2, 32'hA0);
      set_lane(0, 5'd3, 32'hB0);
      tick();
      chk_bc("rereq.2", 3'b100, 1'b1, 5'd8, 32'hA2);
      Breq[2] = 1'b0;
      tick();
      chk_bc("rereq.0b", 3'b001, 1'b1, 5'd3, 32'hB0);
      Breq[0] = 1'b0;
      tick();
      chk_bc("rereq.idle", 3'b000, 1'b0, 5'd0, 32'h0);

      // Hold for two cycles with group 2 requesting
      hold = 1'b1; set_lane(2, 5'd9, 32'hC2); Breq = 3'b100;
      tick();
      chk_bc("hold.1", 3'b000, 1'b0, 5'd0, 32'h0);
      tick();
      chk_bc("hold.2", 3'b000, 1'b0, 5'd0, 32'h0);
      hold = 1'b0;
      tick();
      chk_bc("hold.rel", 3'b100, 1'b1, 5'd9, 32'hC2);
      Breq = 3'b000;
      tick();
      chk_bc("hold.idle", 3'b000, 1'b0, 5'd0, 32'h0);

      // Zero-tag request: acked, no broadcast, sticky error
      set_lane(0, 5'd0, 32'h55); Breq = 3'b001;
      tick();
      chk_bc("ztag", 3'b001, 1'b0, 5'd0, 32'h0);
      chk("ztag.err", 64'(zero_tag_err), 64'd1);
      Breq = 3'b010; set_lane(1, 5'd5, 32'h66);
      tick();
      chk_bc("ztag.next", 3'b010, 1'b1, 5'd5, 32'h66);
      chk("ztag.err2", 64'(zero_tag_err), 64'd1);
      Breq = 3'b000;
      tick();
      chk("ztag.err3", 64'(zero_tag_err), 64'd1);

      // Async reset during an active broadcast (pointer would otherwise pick group 1)
      set_lane(0, 5'd1, 32'h77); Breq = 3'b001;
      tick();
      chk_bc("rst.pre", 3'b001, 1'b1, 5'd1, 32'h77);
      set_lane(1, 5'd4, 32'h88); Breq = 3'b011;
      #2 nRST = 1'b0;
      #1;
      chk_bc("rst.mid", 3'b000, 1'b0, 5'd0, 32'h0);
      chk("rst.mid.err",  64'(zero_tag_err), 64'd0);
      chk("rst.mid.gidx", 64'(grant_idx), 64'd0);
      #2 nRST = 1'b1;
      tick();
      chk_bc("rst.post", 3'b001, 1'b1, 5'd1, 32'h77);
      chk("rst.post.gidx", 64'(grant_idx), 64'd0);
      Breq = 3'b000;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus (CDB) arbiter for the Tomasulo core. Collects broadcast requests from the reservation-station groups (add, mul/div, load buffer), grants one per cycle with round-robin fairness, and drives the registered broadcast (`BCEN`, `BClabel`, `BCdata`) seen by every station and the register-status table. It returns a one-cycle `BreqAC` pulse to the winner, which then frees its entry.

## Interface
Parameters:
- `N`, 3, number of requesting station groups (index 0 = ADD, 1 = MUL, 2 = LOAD)
- `TAG_W`, 5, station tag width; tag 0 means "no producer"
- `DATA_W`, 32, result width

Ports:
- `clk`  in  1  single clock, all state on posedge
- `nRST`  in  1  reset, asynchronous and active-low
- `Breq`  in  N  per-group request; held high until acked
- `BreqLabel`  in  N*TAG_W  packed producer tags, group i at `[i*TAG_W +: TAG_W]`
- `BreqData`  in  N*DATA_W  packed results, group i at `[i*DATA_W +: DATA_W]`
- `hold`  in  1  suppress new grants this cycle (debug/stall)
- `BreqAC`  out  N  one-hot, one-cycle acknowledge
- `BCEN`  out  1  broadcast valid
- `BClabel`  out  TAG_W  broadcast tag
- `BCdata`  out  DATA_W  broadcast value
- `grant_idx`  out  2  index of the current grant, valid with `BreqAC != 0`
- `zero_tag_err`  out  1  sticky: a request carried tag 0

## Operation
- Eligible set each cycle: `Breq & ~BreqAC`. A group whose ack is high this cycle is excluded, so a requester that drops `Breq` on the edge after ack is never double-granted.
- If `hold` is low and the eligible set is non-empty, pick the winner by round robin starting at pointer `rr_ptr`. On the edge: `BreqAC[w]`=1, `grant_idx`=w, `rr_ptr` = (w+1) mod N. Broadcast outputs load the winner's tag and data.
- If the winner's tag is 0, it is still acked and `rr_ptr` advances. `BCEN` stays 0, `BClabel`/`BCdata` = 0, and `zero_tag_err` sets and stays set until reset.
- No grant, because of `hold` or an empty set: `BreqAC`=0, `BCEN`=0, `BClabel`=0, `BCdata`=0, and `rr_ptr` is unchanged.
- Two-state control:
  - IDLE → BCAST on a grant.
  - BCAST → BCAST on another grant.
  - BCAST → IDLE when there is no grant.
  - `BCEN` is asserted only in BCAST with a nonzero tag.
- Requesters must hold `BreqLabel`/`BreqData` stable while `Breq` is high. The arbiter samples them only on the granting edge.

## Timing
- Reset values: `BreqAC`=0, `BCEN`=0, `BClabel`=0, `BCdata`=0, `grant_idx`=0, `zero_tag_err`=0, `rr_ptr`=0, state IDLE. Reset mid-broadcast clears all of these immediately (async), with no pending grant retained.
- Latency: `Breq` sampled high at edge k gives `BreqAC` and `BCEN` high after edge k, i.e. during cycle k+1, for exactly one cycle.
- Throughput: one broadcast per cycle. Different groups can be granted back-to-back. The same group is granted at most every other cycle.
- `hold` is sampled at the edge. A hold during an active broadcast does not truncate it: the current one-cycle pulse completes and no new grant is made.
- Stations consume `BCEN`/`BClabel`/`BCdata` on the next posedge. Outputs are register-driven, with no combinational path from `Breq` to any output.

## Structure
- Shared package `tomasulo_pkg`:
  - `TAG_W`, `DATA_W`
  - station tag constants (ADD0..2, MUL0..2, LOAD0..2)
  - group index constants `GRP_ADD`=0, `GRP_MUL`=1, `GRP_LOAD`=2
- One combinational sub-module `rr_pick`: inputs eligible vector and `rr_ptr`; outputs one-hot winner, winner index, and `any`.
- Top level holds `rr_ptr`, the state, the output registers and the error flag.

## Test plan
- Single request: group 1 with tag MUL0 (5'd4), data 32'h0000_0030. Expect `BreqAC`=3'b010, `BCEN`=1, `BClabel`=4, `BCdata`=32'h30 one cycle after, then `BCEN`=0.
- All three request at once from reset (`rr_ptr`=0). Expect grants 0, 1, 2 on consecutive cycles, each requester dropping `Breq` after its ack, with `BCEN` high for 3 cycles.
- Group 0 re-requests immediately after its ack while group 2 is also requesting. Expect order 0, 2, 0 and never 0, 0 back-to-back.
- `hold`=1 for 2 cycles with group 2 requesting. Expect no ack and `BCEN`=0 during hold, then a grant on the first cycle after hold drops.
- Group 0 requests with tag 0. Expect `BreqAC`=3'b001, `BCEN`=0, `zero_tag_err`=1 sticky, and the next valid request still broadcasts normally.
- Assert `nRST` low in the middle of the cycle while `BCEN`=1. Expect all outputs 0 immediately, and after release a pending request is granted from `rr_ptr`=0.
